// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Buffers register-file writebacks and drains them, one per cycle, into the
// register file's single write port. Two combinational lookup ports expose
// pending writes (youngest entry wins), so the register file's read data,
// combined with this block's forwarding, gives the architectural value.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         producer handshake (in_addr, in_data)
//   drain_hold                suppress draining this cycle
//   rf_write_enable/addr/data register file write port
//   lk_addrN -> lk_hitN,      lookup ports (N = 1, 2)
//     lk_dataN
//   count, empty, full        occupancy (derived from registered state only)
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready are
// both high; in_ready depends only on registered state (!full), never on
// in_valid. Beats to register 0 transfer but are not stored.
// -----------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_hold,
  output logic                     rf_write_enable,
  output logic [ADDR_W-1:0]        rf_write_addr,
  output logic [DATA_W-1:0]        rf_write_data,
  input  logic [ADDR_W-1:0]        lk_addr1,
  input  logic [ADDR_W-1:0]        lk_addr2,
  output logic                     lk_hit1,
  output logic                     lk_hit2,
  output logic [DATA_W-1:0]        lk_data1,
  output logic [DATA_W-1:0]        lk_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is not reset: occupancy masks stale contents.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  lk_idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign in_ready = !full;

  // Writes to x0 complete the handshake but leave the queue untouched.
  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop  = rf_write_enable;

  assign rf_write_enable = !empty && !drain_hold;
  assign rf_write_addr   = empty ? '0 : addr_q[head_q];
  assign rf_write_data   = empty ? '0 : data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Walk entries oldest to youngest; a later match overwrites an earlier one,
  // so the youngest matching entry wins. The head being drained this cycle is
  // still included.
  always_comb begin
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    lk_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if (i < int'(count_q)) begin
        if ((lk_addr1 != '0) && (addr_q[lk_idx] == lk_addr1)) begin
          lk_hit1  = 1'b1;
          lk_data1 = data_q[lk_idx];
        end
        if ((lk_addr2 != '0) && (addr_q[lk_idx] == lk_addr2)) begin
          lk_hit2  = 1'b1;
          lk_data2 = data_q[lk_idx];
        end
      end
    end
  end

endmodule
